// File: rtl/aes_inv_key_schedule_if.sv
// Key-in / round-key-out handshake bundle for the AES-128 inverse key schedule.
interface aes_inv_key_schedule_if;
  logic         key_valid;
  logic         key_ready;
  logic [127:0] key_in;
  logic         rk_valid;
  logic         rk_ready;
  logic [127:0] rk_data;
  logic [3:0]   rk_round;
  logic         rk_last;

  modport master (
    output key_valid, key_in, rk_ready,
    input  key_ready, rk_valid, rk_data, rk_round, rk_last
  );

  modport slave (
    input  key_valid, key_in, rk_ready,
    output key_ready, rk_valid, rk_data, rk_round, rk_last
  );
endinterface

// File: rtl/aes_inv_key_schedule.sv
// Iterative AES-128 inverse key schedule: emits round keys NR..0 on a valid/ready stream.
// Optional INV_KS_SBOX_PIPE_EN inserts a register after the Sbox (one key per two cycles).

// Combinational AES Sbox: GF(2^8) inverse followed by the affine transform.
module aes_sbox (
  input  logic [7:0] in_byte,
  output logic [7:0] out_byte
);
  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] aa;
    p  = 8'h00;
    aa = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) begin
        p = p ^ aa;
      end else begin
        p = p;
      end
      if (aa[7]) begin
        aa = {aa[6:0], 1'b0} ^ 8'h1b;
      end else begin
        aa = {aa[6:0], 1'b0};
      end
    end
    return p;
  endfunction

  // x^254 is the multiplicative inverse, with 0 mapping to 0.
  function automatic logic [7:0] gf_inv(input logic [7:0] a);
    logic [7:0] sq;
    logic [7:0] res;
    sq  = a;
    res = 8'h01;
    for (int k = 1; k < 8; k++) begin
      sq  = gf_mul(sq, sq);
      res = gf_mul(res, sq);
    end
    return res;
  endfunction

  function automatic logic [7:0] affine(input logic [7:0] x);
    return x ^ {x[6:0], x[7]} ^ {x[5:0], x[7:6]} ^ {x[4:0], x[7:5]}
             ^ {x[3:0], x[7:4]} ^ 8'h63;
  endfunction

  logic [7:0] inv_s;

  // Substitution value for one byte.
  always_comb begin
    inv_s    = gf_inv(in_byte);
    out_byte = affine(inv_s);
  end
endmodule

module aes_inv_key_schedule #(
  parameter int NR         = 10,
  parameter bit EMIT_FIRST = 1'b1
) (
  input  logic                   clk,
  input  logic                   rst,
  aes_inv_key_schedule_if.slave  ks,
  output logic                   busy
);
  typedef enum logic [1:0] {IDLE = 2'd0, EMIT = 2'd1, PIPE = 2'd2} state_t;

  function automatic logic [7:0] rcon(input logic [3:0] round);
    logic [7:0] r;
    case (round)
      4'd10:   r = 8'h36;
      4'd9:    r = 8'h1b;
      4'd8:    r = 8'h80;
      4'd7:    r = 8'h40;
      4'd6:    r = 8'h20;
      4'd5:    r = 8'h10;
      4'd4:    r = 8'h08;
      4'd3:    r = 8'h04;
      4'd2:    r = 8'h02;
      4'd1:    r = 8'h01;
      default: r = 8'h00;
    endcase
    return r;
  endfunction

  // Undo one expansion round; sub is SubWord(RotWord(w3 ^ w2)) of the input key.
  function automatic logic [127:0] inv_step(input logic [127:0] key, input logic [31:0] sub,
                                            input logic [3:0] round);
    logic [31:0] p0, p1, p2, p3;
    p3 = key[31:0]   ^ key[63:32];
    p2 = key[63:32]  ^ key[95:64];
    p1 = key[95:64]  ^ key[127:96];
    p0 = key[127:96] ^ sub ^ {rcon(round), 24'h000000};
    return {p0, p1, p2, p3};
  endfunction

  state_t       state_r;
  logic         rk_valid_r;
  logic [127:0] rk_data_r;
  logic [3:0]   rk_round_r;
  logic         rk_last_r;
  logic         busy_r;
  logic [127:0] src_key_s;
  logic [31:0]  rot_s;
  logic [31:0]  sub_s;
`ifdef INV_KS_SBOX_PIPE_EN
  logic [31:0]  sub_r;
  logic [127:0] pipe_key_s;
`else
  logic [3:0]   src_round_s;
  logic [127:0] next_key_s;
`endif

  // While idle the Sbox looks at the incoming key so EMIT_FIRST=0 can step it on accept.
  always_comb begin
    if (state_r == IDLE) begin
      src_key_s = ks.key_in;
    end else begin
      src_key_s = rk_data_r;
    end
    rot_s = {src_key_s[23:0] ^ src_key_s[55:32], src_key_s[31:24] ^ src_key_s[63:56]};
  end

  for (genvar i = 0; i < 4; i++) begin : g_sbox
    aes_sbox u_sbox (
      .in_byte  (rot_s[8*i +: 8]),
      .out_byte (sub_s[8*i +: 8])
    );
  end

`ifdef INV_KS_SBOX_PIPE_EN
  // Second half of the split step, fed from the registered Sbox word.
  always_comb begin
    pipe_key_s = inv_step(rk_data_r, sub_r, rk_round_r);
  end
`else
  // Single-cycle step from whichever key the Sbox is looking at.
  always_comb begin
    if (state_r == IDLE) begin
      src_round_s = 4'(NR);
    end else begin
      src_round_s = rk_round_r;
    end
    next_key_s = inv_step(src_key_s, sub_s, src_round_s);
  end
`endif

  // Sequencer: accept a key, then walk the rounds down to 0 under rk_ready.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r    <= IDLE;
      rk_valid_r <= 1'b0;
      rk_data_r  <= 128'h0;
      rk_round_r <= 4'd0;
      rk_last_r  <= 1'b0;
      busy_r     <= 1'b0;
`ifdef INV_KS_SBOX_PIPE_EN
      sub_r      <= 32'h0;
`endif
    end else begin
      case (state_r)
        IDLE: begin
          if (ks.key_valid) begin
            busy_r <= 1'b1;
            if (EMIT_FIRST) begin
              rk_data_r  <= ks.key_in;
              rk_round_r <= 4'(NR);
              rk_last_r  <= 1'b0;
              rk_valid_r <= 1'b1;
              state_r    <= EMIT;
            end else begin
`ifdef INV_KS_SBOX_PIPE_EN
              rk_data_r  <= ks.key_in;
              rk_round_r <= 4'(NR);
              sub_r      <= sub_s;
              rk_valid_r <= 1'b0;
              state_r    <= PIPE;
`else
              rk_data_r  <= next_key_s;
              rk_round_r <= 4'(NR) - 4'd1;
              rk_last_r  <= (4'(NR) == 4'd1);
              rk_valid_r <= 1'b1;
              state_r    <= EMIT;
`endif
            end
          end else begin
            rk_valid_r <= 1'b0;
          end
        end
        EMIT: begin
          if (ks.rk_ready) begin
            if (rk_round_r == 4'd0) begin
              rk_valid_r <= 1'b0;
              rk_last_r  <= 1'b0;
              busy_r     <= 1'b0;
              state_r    <= IDLE;
            end else begin
`ifdef INV_KS_SBOX_PIPE_EN
              sub_r      <= sub_s;
              rk_valid_r <= 1'b0;
              state_r    <= PIPE;
`else
              rk_data_r  <= next_key_s;
              rk_round_r <= rk_round_r - 4'd1;
              rk_last_r  <= (rk_round_r == 4'd1);
              rk_valid_r <= 1'b1;
`endif
            end
          end else begin
            rk_valid_r <= rk_valid_r;
          end
        end
        PIPE: begin
`ifdef INV_KS_SBOX_PIPE_EN
          rk_data_r  <= pipe_key_s;
          rk_round_r <= rk_round_r - 4'd1;
          rk_last_r  <= (rk_round_r == 4'd1);
          rk_valid_r <= 1'b1;
          state_r    <= EMIT;
`else
          rk_valid_r <= 1'b0;
          busy_r     <= 1'b0;
          state_r    <= IDLE;
`endif
        end
        default: begin
          rk_valid_r <= 1'b0;
          rk_last_r  <= 1'b0;
          busy_r     <= 1'b0;
          state_r    <= IDLE;
        end
      endcase
    end
  end

  assign ks.key_ready = (state_r == IDLE);
  assign ks.rk_valid  = rk_valid_r;
  assign ks.rk_data   = rk_data_r;
  assign ks.rk_round  = rk_round_r;
  assign ks.rk_last   = rk_last_r;
  assign busy         = busy_r;
endmodule
